// File: rtl/wfetch_cmd_ctrl.sv
// Weight-fetch MM2S initiator: turns column indices into datamover commands, then frames and forwards
// the returned weight beats to the PE array.
module wfetch_cmd_ctrl #(
    parameter int NUM_PE        = 8,
    parameter int W_BW          = 8,
    parameter int LAYER_SIZE_BW = 10,
    parameter int MAX_OUT       = 4
) (
    input  logic                     s_axi_aclk,
    input  logic                     s_axi_areset,
    input  logic [31:0]              cfg_base_addr,
    input  logic [LAYER_SIZE_BW-1:0] cfg_col_beats,
    input  logic                     s_axis_idx_tvalid,
    output logic                     s_axis_idx_tready,
    input  logic [LAYER_SIZE_BW-1:0] s_axis_idx_tdata,
    input  logic                     s_axis_idx_tlast,
    output logic                     m_axis_cmd_tvalid,
    input  logic                     m_axis_cmd_tready,
    output logic [79:0]              m_axis_cmd_tdata,
    input  logic                     s_axis_w_tvalid,
    output logic                     s_axis_w_tready,
    input  logic [NUM_PE*W_BW-1:0]   s_axis_w_tdata,
    input  logic                     s_axis_w_tlast,
    output logic                     m_axis_w_tvalid,
    input  logic                     m_axis_w_tready,
    output logic [NUM_PE*W_BW-1:0]   m_axis_w_tdata,
    output logic                     m_axis_w_tlast,
    output logic [1:0]               err,
    output logic                     busy
);

    localparam int BEAT_BYTES = (NUM_PE * W_BW) / 8;
    localparam int PTR_W      = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W      = $clog2(MAX_OUT) + 1;
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

    typedef enum logic [0:0] {
        CMD_IDLE  = 1'b0,
        CMD_ISSUE = 1'b1
    } cmd_state_t;

    cmd_state_t               state_r;
    cmd_state_t               state_nxt_s;
    logic [CNT_W-1:0]         outstanding_r;
    logic [LAYER_SIZE_BW-1:0] beat_cnt_r;
    logic [LAYER_SIZE_BW-1:0] col_beats_r;
    logic [31:0]              base_r;
    logic [3:0]               tag_r;
    logic [1:0]               err_r;
    logic                     first_r;
    logic [79:0]              cmd_data_r;
    logic                     cmd_last_r;
    logic [MAX_OUT-1:0]       flag_mem_r;
    logic [PTR_W-1:0]         wr_ptr_r;
    logic [PTR_W-1:0]         rd_ptr_r;

    logic                     idx_ready_s;
    logic                     idx_hs_s;
    logic                     push_s;
    logic                     pop_s;
    logic                     beat_hs_s;
    logic                     end_col_s;
    logic                     fifo_nonempty_s;
    logic [LAYER_SIZE_BW-1:0] eff_cb_s;
    logic [31:0]              eff_base_s;
    logic [22:0]              btt_s;
    logic [31:0]              saddr_s;

    // The first index of a sequence uses the live cfg values; later ones use the latched copy.
    assign eff_cb_s   = first_r ? cfg_col_beats : col_beats_r;
    assign eff_base_s = first_r ? cfg_base_addr : base_r;
    assign btt_s      = 23'(eff_cb_s) * 23'(BEAT_BYTES);
    assign saddr_s    = eff_base_s + 32'(s_axis_idx_tdata) * 32'(eff_cb_s) * 32'(BEAT_BYTES);

    assign fifo_nonempty_s = (outstanding_r != {CNT_W{1'b0}});
    assign idx_hs_s        = s_axis_idx_tvalid & s_axis_idx_tready;
    assign push_s          = (state_r == CMD_ISSUE) & m_axis_cmd_tready;
    assign beat_hs_s       = s_axis_w_tvalid & s_axis_w_tready;
    assign end_col_s       = (beat_cnt_r == (col_beats_r - LAYER_SIZE_BW'(1)));
    assign pop_s           = beat_hs_s & end_col_s;

    assign s_axis_idx_tready = idx_ready_s & ~s_axi_areset;
    assign m_axis_cmd_tvalid = (state_r == CMD_ISSUE);
    assign m_axis_cmd_tdata  = cmd_data_r;
    assign m_axis_w_tvalid   = s_axis_w_tvalid & fifo_nonempty_s;
    assign s_axis_w_tready   = m_axis_w_tready & fifo_nonempty_s;
    assign m_axis_w_tdata    = s_axis_w_tdata;
    assign m_axis_w_tlast    = end_col_s & flag_mem_r[rd_ptr_r] & fifo_nonempty_s;
    assign err               = err_r;
    assign busy              = (state_r != CMD_IDLE) | fifo_nonempty_s;

    // Command FSM next-state and index acceptance.
    always_comb begin
        state_nxt_s = state_r;
        idx_ready_s = 1'b0;
        case (state_r)
            CMD_IDLE: begin
                idx_ready_s = (outstanding_r < MAX_OUT_C);
                if (s_axis_idx_tvalid && idx_ready_s && (eff_cb_s != LAYER_SIZE_BW'(0))) begin
                    state_nxt_s = CMD_ISSUE;
                end else begin
                    state_nxt_s = CMD_IDLE;
                end
            end
            CMD_ISSUE: begin
                if (m_axis_cmd_tready) begin
                    state_nxt_s = CMD_IDLE;
                end else begin
                    state_nxt_s = CMD_ISSUE;
                end
            end
            default: state_nxt_s = CMD_IDLE;
        endcase
    end

    // Command side: state, sequence config latch, command word build, tag.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_r     <= CMD_IDLE;
            col_beats_r <= LAYER_SIZE_BW'(0);
            base_r      <= 32'd0;
            tag_r       <= 4'd0;
            first_r     <= 1'b1;
            cmd_data_r  <= 80'd0;
            cmd_last_r  <= 1'b0;
            err_r[1]    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (idx_hs_s) begin
                if (first_r) begin
                    col_beats_r <= cfg_col_beats;
                    base_r      <= cfg_base_addr;
                end
                first_r <= s_axis_idx_tlast;
                if (eff_cb_s == LAYER_SIZE_BW'(0)) begin
                    err_r[1] <= 1'b1;
                end else begin
                    cmd_data_r <= {12'd0, tag_r, saddr_s, 1'b0, 1'b1, 6'd0, 1'b1, btt_s};
                    cmd_last_r <= s_axis_idx_tlast;
                end
            end
            if (push_s) begin
                tag_r <= tag_r + 4'd1;
            end
        end
    end

    // Outstanding count and the per-command last-of-sequence flag FIFO.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            outstanding_r <= {CNT_W{1'b0}};
            flag_mem_r    <= {MAX_OUT{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                flag_mem_r[wr_ptr_r] <= cmd_last_r;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
                2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Beat counter; framing follows the count, the datamover's tlast only feeds the error flag.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            beat_cnt_r <= LAYER_SIZE_BW'(0);
            err_r[0]   <= 1'b0;
        end else if (beat_hs_s) begin
            if (end_col_s) begin
                beat_cnt_r <= LAYER_SIZE_BW'(0);
            end else begin
                beat_cnt_r <= beat_cnt_r + LAYER_SIZE_BW'(1);
            end
            if (s_axis_w_tlast != end_col_s) begin
                err_r[0] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wfetch_cmd_ctrl.sv
// Directed self-checking bench for wfetch_cmd_ctrl (NUM_PE=8, W_BW=8 -> 8-byte beats, MAX_OUT=4).
module tb_wfetch_cmd_ctrl;

    logic        s_axi_aclk = 1'b0;
    logic        s_axi_areset;
    logic [31:0] cfg_base_addr;
    logic [9:0]  cfg_col_beats;
    logic        s_axis_idx_tvalid;
    logic        s_axis_idx_tready;
    logic [9:0]  s_axis_idx_tdata;
    logic        s_axis_idx_tlast;
    logic        m_axis_cmd_tvalid;
    logic        m_axis_cmd_tready;
    logic [79:0] m_axis_cmd_tdata;
    logic        s_axis_w_tvalid;
    logic        s_axis_w_tready;
    logic [63:0] s_axis_w_tdata;
    logic        s_axis_w_tlast;
    logic        m_axis_w_tvalid;
    logic        m_axis_w_tready;
    logic [63:0] m_axis_w_tdata;
    logic        m_axis_w_tlast;
    logic [1:0]  err;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [79:0] cmd_q[$];
    logic [64:0] w_q[$];

    wfetch_cmd_ctrl #(.NUM_PE(8), .W_BW(8), .LAYER_SIZE_BW(10), .MAX_OUT(4)) dut (
        .s_axi_aclk(s_axi_aclk), .s_axi_areset(s_axi_areset),
        .cfg_base_addr(cfg_base_addr), .cfg_col_beats(cfg_col_beats),
        .s_axis_idx_tvalid(s_axis_idx_tvalid), .s_axis_idx_tready(s_axis_idx_tready),
        .s_axis_idx_tdata(s_axis_idx_tdata), .s_axis_idx_tlast(s_axis_idx_tlast),
        .m_axis_cmd_tvalid(m_axis_cmd_tvalid), .m_axis_cmd_tready(m_axis_cmd_tready),
        .m_axis_cmd_tdata(m_axis_cmd_tdata),
        .s_axis_w_tvalid(s_axis_w_tvalid), .s_axis_w_tready(s_axis_w_tready),
        .s_axis_w_tdata(s_axis_w_tdata), .s_axis_w_tlast(s_axis_w_tlast),
        .m_axis_w_tvalid(m_axis_w_tvalid), .m_axis_w_tready(m_axis_w_tready),
        .m_axis_w_tdata(m_axis_w_tdata), .m_axis_w_tlast(m_axis_w_tlast),
        .err(err), .busy(busy)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    // Record every completed handshake on the two outgoing streams.
    always @(negedge s_axi_aclk) begin
        if (!s_axi_areset) begin
            if (m_axis_cmd_tvalid && m_axis_cmd_tready) cmd_q.push_back(m_axis_cmd_tdata);
            if (m_axis_w_tvalid && m_axis_w_tready) w_q.push_back({m_axis_w_tlast, m_axis_w_tdata});
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [79:0] mk_cmd(input logic [3:0] tag, input logic [31:0] saddr,
                                           input logic [22:0] btt);
        return {12'h000, tag, saddr, 9'b010000001, btt};
    endfunction

    task automatic tick();
        @(posedge s_axi_aclk);
        #1;
    endtask

    task automatic do_reset();
        s_axi_areset = 1'b1;
        s_axis_idx_tvalid = 1'b0; s_axis_idx_tdata = 10'd0; s_axis_idx_tlast = 1'b0;
        s_axis_w_tvalid = 1'b0; s_axis_w_tdata = 64'd0; s_axis_w_tlast = 1'b0;
        m_axis_cmd_tready = 1'b1; m_axis_w_tready = 1'b1;
        cfg_base_addr = 32'h0000_1000; cfg_col_beats = 10'd4;
        tick(); tick();
        s_axi_areset = 1'b0;
        tick();
        cmd_q.delete();
        w_q.delete();
    endtask

    task automatic send_idx(input logic [9:0] idx, input logic last, input bit rnd);
        if (rnd) repeat ($urandom_range(0, 3)) tick();
        s_axis_idx_tvalid = 1'b1; s_axis_idx_tdata = idx; s_axis_idx_tlast = last;
        for (int n = 0; n < 400; n++) begin
            if (s_axis_idx_tready) begin
                tick();
                s_axis_idx_tvalid = 1'b0;
                return;
            end
            tick();
        end
        s_axis_idx_tvalid = 1'b0;
        n_cmp++; n_fail++;
        $display("FAIL idx_accept: index %0d not accepted within 400 cycles", idx);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last, input bit rnd);
        if (rnd) repeat ($urandom_range(0, 2)) tick();
        s_axis_w_tvalid = 1'b1; s_axis_w_tdata = d; s_axis_w_tlast = last;
        for (int n = 0; n < 400; n++) begin
            m_axis_w_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (s_axis_w_tready) begin
                tick();
                s_axis_w_tvalid = 1'b0;
                return;
            end
            tick();
        end
        s_axis_w_tvalid = 1'b0;
        n_cmp++; n_fail++;
        $display("FAIL beat_accept: beat %h not accepted within 400 cycles", d);
    endtask

    task automatic wait_cmds(input int n);
        for (int k = 0; k < 200 && cmd_q.size() < n; k++) tick();
        n_cmp++;
        if (cmd_q.size() < n) begin
            n_fail++;
            $display("FAIL cmd_count_wait: got %0d commands, need %0d", cmd_q.size(), n);
        end
    endtask

    task automatic test_reset();
        s_axi_areset = 1'b1;
        s_axis_idx_tvalid = 1'b0; s_axis_w_tvalid = 1'b0;
        m_axis_cmd_tready = 1'b0; m_axis_w_tready = 1'b0;
        tick(); tick();
        n_cmp++;
        if (s_axis_idx_tready !== 1'b0) begin
            n_fail++; $display("FAIL rst_idx_tready: got %b want 0", s_axis_idx_tready);
        end
        s_axi_areset = 1'b0;
        tick();
        n_cmp++;
        if ({s_axis_idx_tready, m_axis_cmd_tvalid, s_axis_w_tready, m_axis_w_tvalid, busy, err} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL rst_state: got idx_rdy=%b cmd_v=%b w_rdy=%b w_v=%b busy=%b err=%b want 1,0,0,0,0,00",
                     s_axis_idx_tready, m_axis_cmd_tvalid, s_axis_w_tready, m_axis_w_tvalid, busy, err);
        end
    endtask

    task automatic test_single_column();
        int nl;
        do_reset();
        send_idx(10'd3, 1'b1, 1'b0);
        wait_cmds(1);
        n_cmp++;
        if (cmd_q[0] !== mk_cmd(4'd0, 32'h0000_1060, 23'd32)) begin
            n_fail++; $display("FAIL t1_cmd: got %h want %h", cmd_q[0], mk_cmd(4'd0, 32'h0000_1060, 23'd32));
        end
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_high: got %b want 1", busy); end
        for (int i = 0; i < 4; i++) send_beat(64'hA5A5_0000_0000_00A0 + 64'(i), (i == 3), 1'b0);
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_fall: got %b want 0", busy); end
        nl = 0;
        foreach (w_q[i]) nl += int'(w_q[i][64]);
        n_cmp++;
        if (w_q.size() != 4 || nl != 1 || w_q[3] !== {1'b1, 64'hA5A5_0000_0000_00A3}) begin
            n_fail++; $display("FAIL t1_beats: got %0d beats, %0d tlast, last=%h want 4,1,1a5a50000000000a3",
                               w_q.size(), nl, w_q[w_q.size()-1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr[4];
        int nl;
        addr = '{32'h1000, 32'h1020, 32'h1040, 32'h10A0};
        do_reset();
        m_axis_cmd_tready = 1'b0;
        send_idx(10'd0, 1'b0, 1'b0);
        s_axis_idx_tvalid = 1'b1; s_axis_idx_tdata = 10'd1; s_axis_idx_tlast = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if (s_axis_idx_tready !== 1'b0 || m_axis_cmd_tvalid !== 1'b1 ||
            m_axis_cmd_tdata !== mk_cmd(4'd0, 32'h1000, 23'd32)) begin
            n_fail++; $display("FAIL t2_stall: got idx_rdy=%b cmd_v=%b cmd=%h want 0,1,%h", s_axis_idx_tready,
                               m_axis_cmd_tvalid, m_axis_cmd_tdata, mk_cmd(4'd0, 32'h1000, 23'd32));
        end
        m_axis_cmd_tready = 1'b1;
        send_idx(10'd1, 1'b0, 1'b0);
        send_idx(10'd2, 1'b0, 1'b0);
        send_idx(10'd5, 1'b1, 1'b0);
        wait_cmds(4);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (cmd_q[i] !== mk_cmd(4'(i), addr[i], 23'd32)) begin
                n_fail++; $display("FAIL t2_cmd%0d: got %h want %h", i, cmd_q[i], mk_cmd(4'(i), addr[i], 23'd32));
            end
        end
        for (int i = 0; i < 16; i++) send_beat(64'(i), (i % 4) == 3, 1'b0);
        nl = 0;
        foreach (w_q[i]) nl += int'(w_q[i][64]);
        n_cmp++;
        if (nl != 1 || w_q[15][64] !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t2_tlast: got %0d tlast, last beat tlast=%b busy=%b want 1,1,0",
                               nl, w_q[15][64], busy);
        end
    endtask

    task automatic test_max_outstanding();
        do_reset();
        for (int i = 0; i < 4; i++) send_idx(10'(i), 1'b0, 1'b0);
        s_axis_idx_tvalid = 1'b1; s_axis_idx_tdata = 10'd4; s_axis_idx_tlast = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (cmd_q.size() != 4 || s_axis_idx_tready !== 1'b0) begin
            n_fail++; $display("FAIL t3_full: got %0d cmds idx_rdy=%b want 4,0", cmd_q.size(), s_axis_idx_tready);
        end
        for (int i = 0; i < 3; i++) send_beat(64'(i), 1'b0, 1'b0);
        n_cmp++;
        if (s_axis_idx_tready !== 1'b0) begin
            n_fail++; $display("FAIL t3_still_full: got idx_rdy=%b want 0", s_axis_idx_tready);
        end
        send_beat(64'd3, 1'b1, 1'b0);
        n_cmp++;
        if (s_axis_idx_tready !== 1'b1) begin
            n_fail++; $display("FAIL t3_freed: got idx_rdy=%b want 1", s_axis_idx_tready);
        end
        send_idx(10'd4, 1'b1, 1'b0);
        wait_cmds(5);
        n_cmp++;
        if (cmd_q[4] !== mk_cmd(4'd4, 32'h1080, 23'd32)) begin
            n_fail++; $display("FAIL t3_cmd5: got %h want %h", cmd_q[4], mk_cmd(4'd4, 32'h1080, 23'd32));
        end
    endtask

    task automatic test_random_gaps();
        int bad;
        int nl;
        do_reset();
        cfg_col_beats = 10'd2;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send_idx(10'(i * 3), i == 15, 1'b1);
                    if (i == 0) begin cfg_col_beats = 10'd7; cfg_base_addr = 32'h0000_9000; end
                end
            end
            begin
                for (int i = 0; i < 32; i++) send_beat({32'hC0DE_0000, 32'(i)}, (i % 2) == 1, 1'b1);
            end
        join
        m_axis_w_tready = 1'b1;
        cfg_col_beats = 10'd4; cfg_base_addr = 32'h0000_1000;
        bad = 0; nl = 0;
        foreach (w_q[i]) begin
            if (w_q[i][63:0] !== {32'hC0DE_0000, 32'(i)}) bad++;
            nl += int'(w_q[i][64]);
        end
        n_cmp++;
        if (w_q.size() != 32 || bad != 0) begin
            n_fail++; $display("FAIL t4_data: got %0d beats with %0d wrong want 32,0", w_q.size(), bad);
        end
        n_cmp++;
        if (nl != 1 || w_q[31][64] !== 1'b1 || err !== 2'b00) begin
            n_fail++; $display("FAIL t4_frame: got %0d tlast last=%b err=%b want 1,1,00", nl, w_q[31][64], err);
        end
        n_cmp++;
        if (cmd_q[1] !== mk_cmd(4'd1, 32'h1030, 23'd16) || cmd_q[15] !== mk_cmd(4'd15, 32'h12D0, 23'd16)) begin
            n_fail++; $display("FAIL t4_cfg_hold: got %h / %h want %h / %h", cmd_q[1], cmd_q[15],
                               mk_cmd(4'd1, 32'h1030, 23'd16), mk_cmd(4'd15, 32'h12D0, 23'd16));
        end
    endtask

    task automatic test_errors();
        do_reset();
        send_idx(10'd0, 1'b1, 1'b0);
        wait_cmds(1);
        send_beat(64'd10, 1'b0, 1'b0);
        send_beat(64'd11, 1'b1, 1'b0);
        n_cmp++;
        if (err !== 2'b01) begin n_fail++; $display("FAIL t5_err0: got %b want 01", err); end
        send_beat(64'd12, 1'b0, 1'b0);
        send_beat(64'd13, 1'b1, 1'b0);
        n_cmp++;
        if (w_q.size() != 4 || w_q[1][64] !== 1'b0 || w_q[3][64] !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t5_frame: got %0d beats tlast1=%b tlast3=%b busy=%b want 4,0,1,0",
                               w_q.size(), w_q[1][64], w_q[3][64], busy);
        end
        cfg_col_beats = 10'd0;
        send_idx(10'd7, 1'b1, 1'b0);
        tick(); tick();
        n_cmp++;
        if (err !== 2'b11 || m_axis_cmd_tvalid !== 1'b0 || cmd_q.size() != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t5_zero_col: got err=%b cmd_v=%b cmds=%0d busy=%b want 11,0,1,0",
                               err, m_axis_cmd_tvalid, cmd_q.size(), busy);
        end
        cfg_col_beats = 10'd4;
    endtask

    task automatic test_col_beats_one();
        do_reset();
        cfg_col_beats = 10'd1;
        send_idx(10'd2, 1'b0, 1'b0);
        send_idx(10'd6, 1'b1, 1'b0);
        wait_cmds(2);
        n_cmp++;
        if (cmd_q[1] !== mk_cmd(4'd1, 32'h1030, 23'd8)) begin
            n_fail++; $display("FAIL cb1_cmd: got %h want %h", cmd_q[1], mk_cmd(4'd1, 32'h1030, 23'd8));
        end
        send_beat(64'd1, 1'b1, 1'b0);
        send_beat(64'd2, 1'b1, 1'b0);
        n_cmp++;
        if (w_q.size() != 2 || w_q[0][64] !== 1'b0 || w_q[1][64] !== 1'b1 || busy !== 1'b0 || err !== 2'b00) begin
            n_fail++; $display("FAIL cb1_frame: got %0d beats tlast=%b%b busy=%b err=%b want 2,01,0,00",
                               w_q.size(), w_q[0][64], w_q[1][64], busy, err);
        end
        cfg_col_beats = 10'd4;
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        cfg_base_addr = 32'hFFFF_FFF0;
        send_idx(10'd1, 1'b1, 1'b0);
        wait_cmds(1);
        n_cmp++;
        if (cmd_q[0] !== mk_cmd(4'd0, 32'h0000_0010, 23'd32)) begin
            n_fail++; $display("FAIL t6_wrap: got %h want %h", cmd_q[0], mk_cmd(4'd0, 32'h0000_0010, 23'd32));
        end
        send_beat(64'd1, 1'b0, 1'b0);
        send_beat(64'd2, 1'b0, 1'b0);
        s_axis_w_tvalid = 1'b1; s_axis_idx_tvalid = 1'b1;
        s_axi_areset = 1'b1;
        tick();
        n_cmp++;
        if ({s_axis_idx_tready, m_axis_cmd_tvalid, s_axis_w_tready, m_axis_w_tvalid, m_axis_w_tlast, busy, err}
            !== 8'b0) begin
            n_fail++; $display("FAIL t6_reset: got idx_rdy=%b cmd_v=%b w_rdy=%b w_v=%b w_last=%b busy=%b err=%b want 0",
                               s_axis_idx_tready, m_axis_cmd_tvalid, s_axis_w_tready, m_axis_w_tvalid,
                               m_axis_w_tlast, busy, err);
        end
        s_axi_areset = 1'b0; s_axis_idx_tvalid = 1'b0;
        tick();
        n_cmp++;
        if (s_axis_idx_tready !== 1'b1 || s_axis_w_tready !== 1'b0 || m_axis_w_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t6_after: got idx_rdy=%b w_rdy=%b w_v=%b busy=%b want 1,0,0,0",
                               s_axis_idx_tready, s_axis_w_tready, m_axis_w_tvalid, busy);
        end
        s_axis_w_tvalid = 1'b0;
        cfg_base_addr = 32'h0000_1000;
    endtask

    initial begin
        cfg_base_addr = 32'h0000_1000; cfg_col_beats = 10'd4;
        s_axis_idx_tdata = 10'd0; s_axis_idx_tlast = 1'b0;
        s_axis_w_tdata = 64'd0; s_axis_w_tlast = 1'b0;
        test_reset();
        test_single_column();
        test_back_to_back();
        test_max_outstanding();
        test_random_gaps();
        test_errors();
        test_col_beats_one();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
